// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and state encoding for the fetch redirect unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic {
        RUN,
        TRAP_WAIT
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush inserts a bubble and wins over hold.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid
);

    logic [31:0] pc_q, pc_d, inst_q, inst_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc_d    = flush ? 32'h0 : hold ? pc_q : pc_in;
        inst_d  = flush ? NOP_INST : hold ? inst_q : inst_in;
        valid_d = flush ? 1'b0 : hold ? valid_q : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= 32'h0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc    = pc_q;
    assign inst  = inst_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: PC, next-PC priority, IF/ID control and redirect counter.
// FETCH_MISALIGN_TRAP_EN turns misaligned branch targets into a trap (TRAP_WAIT).
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        epc_taken,
    input  logic [31:0] epc,
    input  logic        stall,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        flush_id_ex,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr,
    output logic [31:0] redirect_count
);

    logic [31:0] pc_q, pc_d, cnt_q, cnt_d, tgt;
    logic        br_ok, redirect, freeze;

`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_state_t state_q, state_d;
    logic         exc_q, exc_d, bad_br;
    logic [31:0]  addr_q, addr_d;

    // epc has priority, so a misaligned branch alongside it raises nothing
    always_comb begin
        br_ok    = br_taken && state_q == RUN;
        bad_br   = br_ok && !epc_taken && br_target[1:0] != 2'b00;
        tgt      = br_target;
        redirect = epc_taken || (br_ok && !bad_br);
        freeze   = bad_br || state_q == TRAP_WAIT;
        state_d  = epc_taken ? RUN : bad_br ? TRAP_WAIT : state_q;
        exc_d    = bad_br;
        addr_d   = bad_br ? br_target : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            exc_q   <= 1'b0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            addr_q  <= addr_d;
        end
    end

    assign misalign_exc  = exc_q;
    assign misalign_addr = addr_q;
`else
    always_comb begin
        br_ok    = br_taken;
        tgt      = br_target & 32'hFFFF_FFFC;
        redirect = epc_taken || br_taken;
        freeze   = 1'b0;
    end

    assign misalign_exc  = 1'b0;
    assign misalign_addr = 32'h0;
`endif

    always_comb begin
        pc_d  = epc_taken ? epc : redirect ? tgt : (stall || freeze) ? pc_q : pc_q + 32'd4;
        cnt_d = cnt_q + {31'h0, redirect};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= 32'h0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign flush_id_ex    = !rst && (epc_taken || br_ok);
    assign pc_out         = pc_q;
    assign redirect_count = cnt_q;

    if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .hold    (stall),
        .flush   (epc_taken || br_ok || freeze),
        .pc_in   (pc_q),
        .inst_in (inst_in),
        .pc      (if_id_pc),
        .inst    (if_id_inst),
        .valid   (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed vector table plus misalign/reset sequences.
module tb_fetch_redirect_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        rst, br_taken, epc_taken, stall;
    logic [31:0] br_target, epc, inst_in;
    logic [31:0] pc_out, if_id_pc, if_id_inst, misalign_addr, redirect_count;
    logic        if_id_valid, flush_id_ex, misalign_exc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk            (clk),
        .rst            (rst),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .epc_taken      (epc_taken),
        .epc            (epc),
        .stall          (stall),
        .inst_in        (inst_in),
        .pc_out         (pc_out),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst),
        .if_id_valid    (if_id_valid),
        .flush_id_ex    (flush_id_ex),
        .misalign_exc   (misalign_exc),
        .misalign_addr  (misalign_addr),
        .redirect_count (redirect_count)
    );

    typedef struct {
        logic        rst, br, epc_t, stall;
        logic [31:0] tgt, epc, inst;
        logic        flush;
        logic [31:0] pc, ipc, iinst;
        logic        ivalid;
        logic [31:0] cnt;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] t, input logic e,
                         input logic [31:0] ea, input logic s, input logic [31:0] ins);
        @(negedge clk);
        rst = r; br_taken = b; br_target = t; epc_taken = e; epc = ea; stall = s; inst_in = ins;
        #1;
    endtask

    task automatic post(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                        input logic [31:0] iinst, input logic iv, input logic [31:0] cnt);
        @(posedge clk);
        #1;
        chk({tag, ".pc_out"}, pc_out, pc);
        chk({tag, ".if_id_pc"}, if_id_pc, ipc);
        chk({tag, ".if_id_inst"}, if_id_inst, iinst);
        chk({tag, ".if_id_valid"}, {31'h0, if_id_valid}, {31'h0, iv});
        chk({tag, ".redirect_count"}, redirect_count, cnt);
    endtask

    function automatic vec_t mk(logic r, logic b, logic [31:0] t, logic e, logic [31:0] ea,
                                logic s, logic [31:0] ins, logic f, logic [31:0] pc,
                                logic [31:0] ipc, logic [31:0] ii, logic iv, logic [31:0] c);
        vec_t x;
        x.rst = r; x.br = b; x.tgt = t; x.epc_t = e; x.epc = ea; x.stall = s; x.inst = ins;
        x.flush = f; x.pc = pc; x.ipc = ipc; x.iinst = ii; x.ivalid = iv; x.cnt = c;
        return x;
    endfunction

    initial begin
        rst = 1'b1; br_taken = 1'b0; br_target = 32'h0; epc_taken = 1'b0; epc = 32'h0;
        stall = 1'b0; inst_in = I0;
        //        rst br  tgt           epc ea            st ins           fl pc            ipc           inst          v  cnt
        v.push_back(mk(1, 1, 32'h300,     0, 32'h0,         0, I0,          0, 32'h0,        32'h0,        NOP,          0, 0));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, I0,          0, 32'h4,        32'h0,        I0,           1, 0));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, I0,          0, 32'h8,        32'h4,        I0,           1, 0));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, I0,          0, 32'hC,        32'h8,        I0,           1, 0));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, I0,          0, 32'h10,       32'hC,        I0,           1, 0));
        v.push_back(mk(0, 1, 32'h100,     0, 32'h0,         0, I0,          1, 32'h100,      32'h0,        NOP,          0, 1));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, 32'h1234567, 0, 32'h104,      32'h100,      32'h1234567,  1, 1));
        v.push_back(mk(0, 1, 32'h1C,      0, 32'h0,         0, I0,          1, 32'h1C,       32'h0,        NOP,          0, 2));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, I0,          0, 32'h20,       32'h1C,       I0,           1, 2));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         1, 32'hAAAA,    0, 32'h20,       32'h1C,       I0,           1, 2));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         1, 32'hBBBB,    0, 32'h20,       32'h1C,       I0,           1, 2));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, 32'hCCCC,    0, 32'h24,       32'h20,       32'hCCCC,     1, 2));
        v.push_back(mk(0, 1, 32'h200,     1, 32'h80,        1, I0,          1, 32'h80,       32'h0,        NOP,          0, 3));
        v.push_back(mk(0, 1, 32'h300,     0, 32'h0,         1, I0,          1, 32'h300,      32'h0,        NOP,          0, 4));
        v.push_back(mk(0, 0, 32'h0,       1, 32'hFFFFFFF8,  0, I0,          1, 32'hFFFFFFF8, 32'h0,        NOP,          0, 5));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, I0,          0, 32'hFFFFFFFC, 32'hFFFFFFF8, I0,           1, 5));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, 32'hDEADBEEF,0, 32'h0,        32'hFFFFFFFC, 32'hDEADBEEF, 1, 5));
        v.push_back(mk(0, 0, 32'h0,       0, 32'h0,         0, I0,          0, 32'h4,        32'h0,        I0,           1, 5));

        foreach (v[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(v[i].rst, v[i].br, v[i].tgt, v[i].epc_t, v[i].epc, v[i].stall, v[i].inst);
            chk({tag, ".flush_id_ex"}, {31'h0, flush_id_ex}, {31'h0, v[i].flush});
            post(tag, v[i].pc, v[i].ipc, v[i].iinst, v[i].ivalid, v[i].cnt);
            chk({tag, ".misalign_exc"}, {31'h0, misalign_exc}, 32'h0);
        end

        // misaligned branch at PC=4, then a redirect from epc
        drive(0, 1, 32'h102, 0, 32'h0, 0, I0);
        chk("mis.flush", {31'h0, flush_id_ex}, 32'h1);
`ifdef FETCH_MISALIGN_TRAP_EN
        post("mis", 32'h4, 32'h0, NOP, 0, 5);
        chk("mis.exc", {31'h0, misalign_exc}, 32'h1);
        chk("mis.addr", misalign_addr, 32'h102);
        drive(0, 1, 32'h500, 0, 32'h0, 1, I0);
        chk("trap.flush", {31'h0, flush_id_ex}, 32'h0);
        post("trap", 32'h4, 32'h0, NOP, 0, 5);
        chk("trap.exc", {31'h0, misalign_exc}, 32'h0);
        chk("trap.addr", misalign_addr, 32'h0);
        drive(0, 0, 32'h0, 1, 32'h40, 0, I0);
        chk("ret.flush", {31'h0, flush_id_ex}, 32'h1);
        post("ret", 32'h40, 32'h0, NOP, 0, 6);
`else
        post("mis", 32'h100, 32'h0, NOP, 0, 6);
        chk("mis.exc", {31'h0, misalign_exc}, 32'h0);
        chk("mis.addr", misalign_addr, 32'h0);
`endif

        // second misaligned branch, then reset while it is pending
        drive(0, 1, 32'h202, 0, 32'h0, 0, I0);
        @(posedge clk);
        drive(1, 0, 32'h0, 1, 32'h80, 0, I0);
        chk("rst.flush", {31'h0, flush_id_ex}, 32'h0);
        post("rst", 32'h0, 32'h0, NOP, 0, 0);
        chk("rst.exc", {31'h0, misalign_exc}, 32'h0);
        chk("rst.addr", misalign_addr, 32'h0);
        drive(0, 0, 32'h0, 0, 32'h0, 0, I0);
        post("after_rst", 32'h4, 32'h0, I0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
